// File: rtl/cpu_addr_decode_pipe_if.sv
// Request/response bus between the CPU master, the address decoder and the
// memory controller. The master side issues raw CPU requests and accepts
// decoded ones. The slave side is the decoder itself.
interface cpu_addr_decode_pipe_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) ();

  // CPU request channel
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              in_rw;
  logic [DATA_W-1:0] in_wdata;

  // Decoded request channel towards the memory controller
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        out_sel;
  logic              out_mem;
  logic              out_err;
  logic              out_rw;
  logic [DATA_W-1:0] out_wdata;

  modport master (
    output in_valid, in_addr, in_rw, in_wdata, out_ready,
    input  in_ready, out_valid, out_addr, out_sel, out_mem, out_err,
           out_rw, out_wdata
  );

  modport slave (
    input  in_valid, in_addr, in_rw, in_wdata, out_ready,
    output in_ready, out_valid, out_addr, out_sel, out_mem, out_err,
           out_rw, out_wdata
  );

endinterface

// File: rtl/cpu_addr_decode_pipe.sv
// Pipelined CPU address decoder. Each accepted request is classified into
// RAM, PPU registers, IO registers or cartridge space. It is translated to a
// flat address and presented one cycle later from a single output register
// with valid/ready backpressure. Saturating per-region counters record every
// decoded request that leaves the stage.
module cpu_addr_decode_pipe #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RAM_SIZE    = 16'h0800,
  parameter int unsigned PPU_BASE    = 16'h2000,
  parameter int unsigned PPU_REGS    = 8,
  parameter int unsigned IO_BASE     = 16'h4000,
  parameter int unsigned CART_BASE   = 16'h4020,
  parameter int unsigned CART_OFFSET = 16'h0800,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  cpu_addr_decode_pipe_if.slave      bus,
  input  logic                       mirror_en,
  input  logic                       cnt_clr,
  input  logic [1:0]                 cnt_sel,
  output logic [CNT_W-1:0]           cnt_val
);

  localparam logic [ADDR_W-1:0] RAM_MASK = ADDR_W'(RAM_SIZE - 1);
  localparam logic [ADDR_W-1:0] PPU_B    = ADDR_W'(PPU_BASE);
  localparam logic [ADDR_W-1:0] PPU_MASK = ADDR_W'(PPU_REGS - 1);
  localparam logic [ADDR_W-1:0] PPU_END  = ADDR_W'(PPU_BASE + PPU_REGS);
  localparam logic [ADDR_W-1:0] IO_B     = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] CART_B   = ADDR_W'(CART_BASE);
  localparam logic [ADDR_W-1:0] CART_OFF = ADDR_W'(CART_OFFSET);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_PPU  = 2'd1,
    SEL_IO   = 2'd2,
    SEL_CART = 2'd3
  } region_t;

  // Combinational decode of the incoming address
  logic [ADDR_W-1:0] dec_addr;
  region_t           dec_sel;
  logic              dec_mem;
  logic              dec_err;

  // Output stage registers
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  region_t           sel_q;
  logic              mem_q;
  logic              err_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;

  // Region access counters
  logic [CNT_W-1:0]  cnt_q [4];

  logic              xfer_in;
  logic              xfer_out;

  // The stage can take a new request whenever it is empty or is being drained
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign xfer_in      = bus.in_valid && bus.in_ready;
  assign xfer_out     = valid_q && bus.out_ready;

  assign bus.out_valid = valid_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_mem   = mem_q;
  assign bus.out_err   = err_q;
  assign bus.out_rw    = rw_q;
  assign bus.out_wdata = wdata_q;

  // Classify the address by window (lowest window first) and translate it
  always_comb begin
    dec_sel  = SEL_RAM;
    dec_mem  = 1'b1;
    dec_err  = 1'b0;
    dec_addr = bus.in_addr & RAM_MASK;
    if (bus.in_addr < PPU_B) begin
      dec_sel  = SEL_RAM;
      dec_mem  = 1'b1;
      dec_addr = bus.in_addr & RAM_MASK;
    end else if (bus.in_addr < IO_B) begin
      dec_sel  = SEL_PPU;
      dec_mem  = 1'b0;
      dec_addr = PPU_B + (bus.in_addr & PPU_MASK);
      dec_err  = !mirror_en && (bus.in_addr >= PPU_END);
    end else if (bus.in_addr < CART_B) begin
      dec_sel  = SEL_IO;
      dec_mem  = 1'b0;
      dec_addr = bus.in_addr;
    end else begin
      dec_sel  = SEL_CART;
      dec_mem  = 1'b1;
      dec_addr = bus.in_addr - CART_B + CART_OFF;
    end
  end

  // Output register: load on accept, empty on drain, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= SEL_RAM;
      mem_q   <= 1'b0;
      err_q   <= 1'b0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
    end else if (xfer_in) begin
      valid_q <= 1'b1;
      addr_q  <= dec_addr;
      sel_q   <= dec_sel;
      mem_q   <= dec_mem;
      err_q   <= dec_err;
      rw_q    <= bus.in_rw;
      wdata_q <= bus.in_wdata;
    end else if (xfer_out) begin
      valid_q <= 1'b0;
    end
  end

  // Count drained requests per region, saturating; clear overrides counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr) begin
          cnt_q[i] <= '0;
        end else if (xfer_out && (sel_q == region_t'(i[1:0])) &&
                     (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Registered readback of the selected counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_val <= '0;
    end else begin
      cnt_val <= cnt_q[cnt_sel];
    end
  end

endmodule

// File: doc/cpu_addr_decode_pipe.md
# cpu_addr_decode_pipe

Parametrised, pipelined CPU address decoder that sits between the CPU bus master and the memory controller. It accepts CPU bus requests over a valid/ready handshake, classifies each address into RAM, PPU-register, IO-register or cartridge space, and translates it into a flat memory or register address. It forwards the request one cycle later with backpressure support, optional PPU mirroring and saturating per-region access counters.

## Interface
- `ADDR_W`, 16: CPU and translated address width.
- `DATA_W`, 8: write-data width.
- `RAM_SIZE`, 16'h0800: internal RAM size; power of two; RAM window is 0 .. `PPU_BASE`-1.
- `PPU_BASE`, 16'h2000: start of the PPU register window.
- `PPU_REGS`, 8: PPU register count; power of two.
- `IO_BASE`, 16'h4000: start of the IO register window.
- `CART_BASE`, 16'h4020: start of cartridge space, which runs to top of address space.
- `CART_OFFSET`, 16'h0800: translated base address of cartridge space.
- `CNT_W`, 16: access-counter width.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: decoder accepts the request this cycle.
- `in_addr` in `ADDR_W`: CPU address.
- `in_rw` in 1: 1 = read, 0 = write.
- `in_wdata` in `DATA_W`: write data.
- `mirror_en` in 1: 1 = PPU mirroring on; 0 = addresses in `PPU_BASE+PPU_REGS` .. `IO_BASE`-1 are errors.
- `out_valid` out 1: decoded request present.
- `out_ready` in 1: downstream accepts.
- `out_addr` out `ADDR_W`: translated address.
- `out_sel` out 2: 0 RAM, 1 PPU, 2 IO, 3 CART.
- `out_mem` out 1: 1 = memory (RAM/CART), 0 = register (PPU/IO).
- `out_err` out 1: unmapped PPU-mirror access while `mirror_en`=0.
- `out_rw` out 1, `out_wdata` out `DATA_W`: forwarded unchanged.
- `cnt_sel` in 2: selects the region counter.
- `cnt_val` out `CNT_W`: the selected counter, registered.
- `cnt_clr` in 1: synchronous clear of all counters.

## Operation
- Single output register stage. `in_ready` = !`out_valid` | `out_ready`.
- Transfer in = `in_valid` & `in_ready`. Transfer out = `out_valid` & `out_ready`.
- On transfer in, the stage loads the decoded request and sets `out_valid`=1.
- On transfer out with no transfer in, `out_valid` clears to 0.
- While stalled (`out_valid`=1 and `out_ready`=0), every output holds stable.
- Decode of addr `a` (compares unsigned, evaluated in this order):
  - `a` < `PPU_BASE`: sel=0, mem=1, addr = `a` & (`RAM_SIZE`-1).
  - `a` < `IO_BASE`: sel=1, mem=0, addr = `PPU_BASE` + (`a` & (`PPU_REGS`-1)).
    - err=1 only when `mirror_en`=0 and `a` >= `PPU_BASE`+`PPU_REGS`.
  - `a` < `CART_BASE`: sel=2, mem=0, addr = `a`.
  - Otherwise: sel=3, mem=1, addr = `a` - `CART_BASE` + `CART_OFFSET`, truncated to `ADDR_W` (wraps).
- `mirror_en` is sampled on transfer in.
- Errored requests are still forwarded with err=1, and their addr is computed as above.
- Counters:
  - Four `CNT_W` counters, one per sel.
  - Each counter increments on transfer out of its region, including errored requests.
  - Each counter saturates at all-ones.
  - `cnt_clr` takes priority over an increment in the same cycle.

## Timing
- Reset: `out_valid`=0, `out_addr`=0, `out_sel`=0, `out_mem`=0, `out_err`=0, `out_rw`=1, `out_wdata`=0, all counters 0, `cnt_val`=0.
- `in_ready`=1 while in reset and immediately after it.
- Latency: request accepted at edge N appears on outputs after edge N; throughput is 1 per cycle when `out_ready`=1.
- Simultaneous transfer in and transfer out: the new request replaces the old; `out_valid` stays 1 and there is no bubble.
- `cnt_val` = counter[`cnt_sel`] registered, so it is one cycle behind both counter and `cnt_sel`.
- Reset asserted mid-transaction: the pending request is dropped and counters clear; no partial state survives.

## Test plan
- Reset release, `out_ready`=1, stream 0x0000, 0x07FF, 0x0800, 0x1FFF -> each cycle after acceptance: addr 0x0000, 0x07FF, 0x0000, 0x07FF; sel=0; mem=1.
- 0x2007, 0x2008, 0x3FFF with `mirror_en`=1 -> addr 0x2007, 0x2000, 0x2007; sel=1; mem=0; err=0. Repeat with `mirror_en`=0 -> err 0, 1, 1.
- 0x4000, 0x401F, 0x4020, 0xFFFF -> 0x4000, 0x401F (sel=2); 0x0800, 0xC7DF (sel=3, mem=1).
- Backpressure: accept 0x4020, hold `out_ready`=0 for 3 cycles while `in_valid`=1 with 0x0001 -> `in_ready`=0 and outputs stable at 0x0800. After `out_ready`=1, 0x0001 follows with no bubble.
- Counters: 5 RAM and 2 IO transfers, `cnt_sel`=0 then 2 -> `cnt_val`=5 then 2. With `CNT_W`=2 and 5 accesses -> 3. Assert `cnt_clr` together with an increment -> 0.
- Assert `rst` while `out_valid`=1 and stalled -> `out_valid`=0 immediately (asynchronous), counters 0, `in_ready`=1.
